dcm_reprog: RTL and testbench

- Runtime frequency-reprogramming controller for the DCM_CLKGEN-based clock generator.
- Sits directly upstream of the clock generator's PROGCLK/PROGDATA/PROGEN/PROGDONE/LOCKED pins; the generator no longer ties these off.
- Accepts a new M/D pair over a valid/ready handshake, serially loads D then M, issues GO, then waits for PROGDONE and LOCKED.
- Lets firmware retune the hashing clock without reconfiguring the FPGA.

---
 rtl/dcm_reprog.sv | 193 +++++++++++++++++++
 tb/tb_dcm_reprog.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_reprog.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_reprog
//  Purpose  : Serial M/D reprogramming controller for a DCM_CLKGEN clock
//             generator (drives PROGCLK/PROGEN/PROGDATA, watches PROGDONE/LOCKED).
//  Revision : 1.0 - initial release
// ============================================================================
module dcm_reprog #(
    parameter int TIMEOUT = 65535
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_m,
    input  logic [7:0] cfg_d,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       locked
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_D = 4'd1,
        ST_GAP1   = 4'd2,
        ST_LOAD_M = 4'd3,
        ST_GAP2   = 4'd4,
        ST_GO     = 4'd5,
        ST_FIN    = 4'd6,
        ST_WAIT   = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

    localparam logic [3:0]  c_last_bit  = 4'd9;
    localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_wait_cnt;
    logic [7:0]  r_m;
    logic [7:0]  r_d;
    logic        r_prog_clk;
    logic        r_prog_en;
    logic        r_prog_data;
    logic        r_busy;
    logic        r_ready;
    logic        r_done;
    logic        r_err;

    logic        w_tick;
    logic        w_accept;
    logic [9:0]  w_frame_d;
    logic [9:0]  w_frame_m;

    // A tick is the edge on which prog_clk falls, so each new bit is set up
    // half a prog_clk period before the generator's sampling rising edge.
    assign w_tick    = r_prog_clk;
    assign w_accept  = cfg_valid && r_ready;
    assign w_frame_d = {r_d, 2'b01};
    assign w_frame_m = {r_m, 2'b11};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_wait_cnt  <= 16'd0;
            r_m         <= 8'd0;
            r_d         <= 8'd0;
            r_prog_clk  <= 1'b0;
            r_prog_en   <= 1'b0;
            r_prog_data <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prog_clk <= ~r_prog_clk;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_m       <= cfg_m;
                        r_d       <= cfg_d;
                        r_bit_cnt <= 4'd0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        // M-1 of zero would ask for M=1, which the generator cannot do.
                        if (cfg_m == 8'd0) begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end else begin
                            r_state <= ST_LOAD_D;
                        end
                    end
                end
                ST_LOAD_D: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b1;
                        r_prog_data <= w_frame_d[r_bit_cnt];
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_GAP1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_GAP1: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b0;
                        r_prog_data <= 1'b0;
                        r_state     <= ST_LOAD_M;
                    end
                end
                ST_LOAD_M: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b1;
                        r_prog_data <= w_frame_m[r_bit_cnt];
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_GAP2;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_GAP2: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b0;
                        r_prog_data <= 1'b0;
                        r_state     <= ST_GO;
                    end
                end
                ST_GO: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b1;
                        r_prog_data <= 1'b0;
                        r_state     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (w_tick) begin
                        r_prog_en   <= 1'b0;
                        r_prog_data <= 1'b0;
                        r_wait_cnt  <= 16'd0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (prog_done && locked) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_prog_en   <= 1'b0;
                    r_prog_data <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign prog_clk  = r_prog_clk;
    assign prog_en   = r_prog_en;
    assign prog_data = r_prog_data;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reprog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcm_reprog
//  Purpose  : Directed self-checking bench for dcm_reprog.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcm_reprog;

    localparam int c_timeout = 100;

    // Bit k of each vector is the value seen at the k-th prog_clk rising edge
    // of a frame: D(10), gap, M(10), gap, GO, final deassert.
    localparam logic [23:0] c_exp_en     = 24'b010_1111111111_0_1111111111;
    localparam logic [23:0] c_exp_dat_24 = 24'b000_0001100011_0_0000111101;
    localparam logic [23:0] c_exp_dat_1  = 24'b000_0000000111_0_0000000001;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_m;
    logic [7:0] cfg_d;
    logic       busy;
    logic       done;
    logic       err;
    logic       prog_clk;
    logic       prog_en;
    logic       prog_data;
    logic       prog_done;
    logic       locked;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    dcm_reprog #(.TIMEOUT(c_timeout)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_m     (cfg_m),
        .cfg_d     (cfg_d),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .prog_clk  (prog_clk),
        .prog_en   (prog_en),
        .prog_data (prog_data),
        .prog_done (prog_done),
        .locked    (locked)
    );

    task automatic request(input logic [7:0] m, input logic [7:0] d);
        @(negedge sys_clk);
        cfg_m     = m;
        cfg_d     = d;
        cfg_valid = 1'b1;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    // Ends one sys_clk cycle after the edge that enters WAIT_DONE.
    task automatic capture(output logic [23:0] en_v, output logic [23:0] dat_v, output bit ok);
        int idx = 0;
        en_v  = '0;
        dat_v = '0;
        for (int cyc = 0; cyc < 200 && idx < 24; cyc++) begin
            @(negedge sys_clk);
            if (prog_clk && (idx > 0 || prog_en)) begin
                en_v[idx]  = prog_en;
                dat_v[idx] = prog_data;
                idx++;
            end
        end
        ok = (idx == 24);
    endtask

    task automatic test_reset;
        sys_rst   = 1'b1;
        cfg_valid = 1'b0;
        cfg_m     = 8'd0;
        cfg_d     = 8'd0;
        prog_done = 1'b0;
        locked    = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({prog_clk, prog_en, prog_data, done, err, busy, cfg_ready} !== 7'b0000001) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 0000001",
                     {prog_clk, prog_en, prog_data, done, err, busy, cfg_ready});
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_program;
        logic [23:0] en_v;
        logic [23:0] dat_v;
        bit          ok;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL prog_ready_idle: got %b required 1", cfg_ready);
        end
        request(8'd24, 8'd15);
        n_cmp++;
        if ({cfg_ready, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL prog_accept: ready/busy got %b required 01", {cfg_ready, busy});
        end
        capture(en_v, dat_v, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL prog_frame_bound: frame incomplete after 200 cycles");
        end
        n_cmp++;
        if (en_v !== c_exp_en) begin
            n_bad++;
            $display("FAIL prog_en_seq: got %b required %b", en_v, c_exp_en);
        end
        n_cmp++;
        if (dat_v !== c_exp_dat_24) begin
            n_bad++;
            $display("FAIL prog_data_seq: got %b required %b", dat_v, c_exp_dat_24);
        end
        repeat (8) @(negedge sys_clk);
        n_cmp++;
        if ({done, err, busy} !== 3'b001) begin
            n_bad++;
            $display("FAIL prog_wait: done/err/busy got %b required 001", {done, err, busy});
        end
        prog_done = 1'b1;
        locked    = 1'b1;
        @(negedge sys_clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_bad++;
            $display("FAIL prog_done_pulse: done/err got %b required 10", {done, err});
        end
        @(negedge sys_clk);
        prog_done = 1'b0;
        locked    = 1'b0;
        n_cmp++;
        if ({done, busy, cfg_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL prog_idle_after: done/busy/ready got %b required 001",
                     {done, busy, cfg_ready});
        end
    endtask

    task automatic test_illegal;
        bit en_seen = 1'b0;
        request(8'd0, 8'h55);
        n_cmp++;
        if ({err, cfg_ready, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL illegal_err: err/ready/busy got %b required 101", {err, cfg_ready, busy});
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({err, cfg_ready, busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL illegal_return: err/ready/busy got %b required 010", {err, cfg_ready, busy});
        end
        for (int i = 0; i < 20; i++) begin
            if (prog_en) en_seen = 1'b1;
            @(negedge sys_clk);
        end
        n_cmp++;
        if (en_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_prog_en: prog_en seen %b required 0", en_seen);
        end
    endtask

    task automatic test_timeout;
        logic [23:0] en_v;
        logic [23:0] dat_v;
        bit          ok;
        bit          early = 1'b0;
        locked = 1'b1;
        request(8'd1, 8'd0);
        capture(en_v, dat_v, ok);
        n_cmp++;
        if (!ok || dat_v !== c_exp_dat_1) begin
            n_bad++;
            $display("FAIL timeout_frame: ok %0d data got %b required %b", ok, dat_v, c_exp_dat_1);
        end
        for (int i = 0; i < 98; i++) begin
            @(negedge sys_clk);
            if (done || err) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: pulse before count got %b required 0", early);
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({err, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_err: err/done got %b required 10", {err, done});
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({err, cfg_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_return: err/ready got %b required 01", {err, cfg_ready});
        end
        locked = 1'b0;
    endtask

    task automatic test_reset_mid_load;
        logic [23:0] en_v;
        logic [23:0] dat_v;
        bit          ok;
        bit          hit = 1'b0;
        bit          seen_done = 1'b0;
        int          idx = 0;
        logic [1:0]  sample = 2'b00;
        request(8'd24, 8'd15);
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge sys_clk);
            if (prog_clk && (idx > 0 || prog_en)) begin
                if (idx == 16) begin
                    hit    = 1'b1;
                    sample = {prog_en, prog_data};
                end
                idx++;
            end
        end
        n_cmp++;
        if (!hit || sample !== 2'b11) begin
            n_bad++;
            $display("FAIL midload_bit5: reached %0d en/data got %b required 11", hit, sample);
        end
        sys_rst = 1'b1;
        #1;
        n_cmp++;
        if ({prog_en, prog_data, prog_clk, busy, cfg_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL midload_async: en/data/clk/busy/ready got %b required 00001",
                     {prog_en, prog_data, prog_clk, busy, cfg_ready});
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        request(8'd24, 8'd15);
        capture(en_v, dat_v, ok);
        n_cmp++;
        if (!ok || en_v !== c_exp_en || dat_v !== c_exp_dat_24) begin
            n_bad++;
            $display("FAIL midload_refresh: ok %0d en %b data %b required en %b data %b",
                     ok, en_v, dat_v, c_exp_en, c_exp_dat_24);
        end
        prog_done = 1'b1;
        locked    = 1'b1;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            @(negedge sys_clk);
            if (done) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b1) begin
            n_bad++;
            $display("FAIL midload_done: done seen %b required 1", seen_done);
        end
        @(negedge sys_clk);
        prog_done = 1'b0;
        locked    = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        int n_acc   = 0;
        int n_done  = 0;
        int n_order = 0;
        bit done_since = 1'b0;
        bit idle_seen  = 1'b0;
        prog_done = 1'b1;
        locked    = 1'b1;
        cfg_m     = 8'd2;
        cfg_d     = 8'd3;
        cfg_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cfg_ready) begin
                if (n_acc > 0 && !done_since) n_order++;
                n_acc++;
                done_since = 1'b0;
            end
            @(negedge sys_clk);
            if (done) begin
                n_done++;
                done_since = 1'b1;
            end
        end
        cfg_valid = 1'b0;
        n_cmp++;
        if (n_acc !== 4) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d required 4", n_acc);
        end
        n_cmp++;
        if (n_order !== 0 || n_done < 3) begin
            n_bad++;
            $display("FAIL b2b_order: early accepts %0d dones %0d required 0 and >=3", n_order, n_done);
        end
        for (int i = 0; i < 100 && !idle_seen; i++) begin
            @(negedge sys_clk);
            if (!busy) idle_seen = 1'b1;
        end
        n_cmp++;
        if (idle_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_idle: idle seen %b required 1", idle_seen);
        end
        prog_done = 1'b0;
        locked    = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_simultaneous;
        logic [23:0] en_v;
        logic [23:0] dat_v;
        bit          ok;
        request(8'd24, 8'd15);
        capture(en_v, dat_v, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL simul_frame_bound: frame incomplete after 200 cycles");
        end
        repeat (98) @(negedge sys_clk);
        prog_done = 1'b1;
        locked    = 1'b1;
        @(negedge sys_clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_bad++;
            $display("FAIL simul_done_wins: done/err got %b required 10", {done, err});
        end
        @(negedge sys_clk);
        prog_done = 1'b0;
        locked    = 1'b0;
        n_cmp++;
        if ({err, cfg_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL simul_return: err/ready got %b required 01", {err, cfg_ready});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_illegal();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
